// File: rtl/rvi_encoder.sv
// rvi_encoder: streaming RV32I instruction encoder feeding a small output FIFO.
// Define RVI_ENCODER_LI_EN to build the load-immediate (LUI/ADDI) expansion.
module rvi_encoder #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_opcode,
  input  logic [9:0]  req_funct,
  input  logic        req_li,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
  output logic        ins_last,
  output logic        ins_error
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic        err;
    logic        last;
    logic [31:0] word;
  } entry_t;

  localparam entry_t ERR_ENTRY = '{err: 1'b1, last: 1'b1, word: 32'd0};

  function automatic logic fits_signed(input logic signed [31:0] v, input int bits);
    logic signed [31:0] t;
    t = (v <<< (32 - bits)) >>> (32 - bits);
    return t == v;
  endfunction

  function automatic entry_t encode(input logic [6:0] op, input logic [9:0] fn,
                                    input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic signed [31:0] imm);
    entry_t     e;
    logic       ok;
    logic [2:0] f3;
    logic [6:0] f7;
    f3     = fn[2:0];
    f7     = fn[9:3];
    ok     = 1'b0;
    e.err  = 1'b0;
    e.last = 1'b1;
    e.word = 32'd0;
    case (op)
      OPC_LUI, OPC_AUIPC: begin
        ok     = (imm[11:0] == 12'd0);
        e.word = {imm[31:12], rd, op};
      end
      OPC_JAL: begin
        ok     = fits_signed(imm, 21) && !imm[0];
        e.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      OPC_JALR: begin
        ok     = fits_signed(imm, 12);
        e.word = {imm[11:0], rs1, 3'b000, rd, op};
      end
      OPC_LOAD: begin
        ok     = fits_signed(imm, 12) && (f7 == 7'd0) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.word = {imm[11:0], rs1, f3, rd, op};
      end
      OPC_OP_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // Shifts carry funct7 in imm[11:5] and the shamt in imm[4:0].
          ok     = ((f7 == 7'd0) || (f3 == 3'b101 && f7 == F7_ALT)) && (imm[31:5] == 27'd0);
          e.word = {f7, imm[4:0], rs1, f3, rd, op};
        end else begin
          ok     = (f7 == 7'd0) && fits_signed(imm, 12);
          e.word = {imm[11:0], rs1, f3, rd, op};
        end
      end
      OPC_STORE: begin
        ok     = fits_signed(imm, 12) && (f7 == 7'd0) && (f3 inside {3'd0, 3'd1, 3'd2});
        e.word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      end
      OPC_BRANCH: begin
        ok     = fits_signed(imm, 13) && !imm[0] && (f7 == 7'd0) && !(f3 inside {3'd2, 3'd3});
        e.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      OPC_OP: begin
        ok     = (f7 == 7'd0) || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
        e.word = {f7, rs2, rs1, f3, rd, op};
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = ERR_ENTRY;
    end
    return e;
  endfunction

  logic signed [31:0] imm_s;
  logic               accept;
  logic               full;
  logic               pop;
  logic               li_busy;
  logic               push_en;
  entry_t             push_entry;
  entry_t             head;
  entry_t             mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        cnt_q, cnt_d;

  assign imm_s     = req_imm;
  assign full      = (cnt_q == FULL_CNT);
  assign req_ready = !rst && !full && !li_busy;
  assign accept    = req_valid && req_ready;
  assign ins_valid = (cnt_q != '0);
  assign pop       = ins_valid && ins_ready;
  assign head      = mem_q[rd_ptr_q];
  assign ins_data  = ins_valid ? head.word : 32'd0;
  assign ins_last  = ins_valid && head.last;
  assign ins_error = ins_valid && head.err;

`ifdef RVI_ENCODER_LI_EN
  typedef enum logic {S_IDLE, S_LI_LO} state_e;

  state_e      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic        li_short;
  logic        li_two;
  logic [31:0] li_addi;
  entry_t      li_first;

  assign li_busy = (state_q == S_LI_LO);

  // hi absorbs the sign of lo so that LUI + sign-extended ADDI rebuilds imm.
  always_comb begin
    li_short = fits_signed(imm_s, 12);
    li_lo    = req_imm[11:0];
    li_hi    = req_imm[31:12] + {19'd0, req_imm[11]};
    li_two   = !li_short && (li_lo != 12'd0);
    li_addi  = {li_lo, req_rd, 3'b000, req_rd, OPC_OP_IMM};
    if (li_short) begin
      li_first = '{err: 1'b0, last: 1'b1, word: {li_lo, 5'd0, 3'b000, req_rd, OPC_OP_IMM}};
    end else begin
      li_first = '{err: 1'b0, last: !li_two, word: {li_hi, req_rd, OPC_LUI}};
    end
  end
`else
  assign li_busy = 1'b0;
`endif

  always_comb begin
    push_en    = 1'b0;
    push_entry = encode(req_opcode, req_funct, req_rd, req_rs1, req_rs2, imm_s);
`ifdef RVI_ENCODER_LI_EN
    state_d = state_q;
    pend_d  = pend_q;
    if (state_q == S_LI_LO) begin
      push_entry = '{err: 1'b0, last: 1'b1, word: pend_q};
      if (!full) begin
        push_en = 1'b1;
        state_d = S_IDLE;
      end
    end else if (accept) begin
      push_en = 1'b1;
      if (req_li) begin
        push_entry = li_first;
        if (li_two) begin
          state_d = S_LI_LO;
          pend_d  = li_addi;
        end
      end
    end
`else
    if (accept) begin
      push_en = 1'b1;
      if (req_li) begin
        push_entry = ERR_ENTRY;
      end
    end
`endif
  end

  // Pushes are only issued while not full, so a full FIFO never pops through.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_en, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
`ifdef RVI_ENCODER_LI_EN
      state_q  <= S_IDLE;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
`ifdef RVI_ENCODER_LI_EN
      state_q  <= state_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
`ifdef RVI_ENCODER_LI_EN
    pend_q <= pend_d;
`endif
  end

endmodule

// File: tb/tb_rvi_encoder.sv
// tb_rvi_encoder: randomized bench for rvi_encoder with a field-level reference
// model and scoreboard; directed cases pin the model to hand-encoded words.
module tb_rvi_encoder;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_opcode;
  logic [9:0]  req_funct;
  logic        req_li;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic        ins_last;
  logic        ins_error;

  always #5 clk = ~clk;

  rvi_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct(req_funct), .req_li(req_li),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
    .ins_last(ins_last), .ins_error(ins_error)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [33:0] exp_q [$];

  logic [6:0] ops [9]  = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33};
  logic [9:0] fns [12] = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h004, 10'h005,
                           10'h006, 10'h007, 10'h100, 10'h105, 10'h101, 10'h080};

  function automatic void chk(input bit ok, input string name,
                              input logic [33:0] act, input logic [33:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endfunction

  // Reference: entries are {error, last, word}; n is the number of words emitted.
  function automatic void model(input logic [6:0] op, input logic [9:0] fn, input logic li,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                output logic [33:0] e0, output logic [33:0] e1, output int n);
    int signed   v;
    int          fv;
    bit          ok;
    logic [31:0] iv, rv, s1, s2, f3, f7, ov, w, hi, lo;
    v  = imm;
    fv = int'(fn);
    iv = imm; rv = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2);
    f3 = 32'(fn[2:0]); f7 = 32'(fn[9:3]); ov = 32'(op);
    n  = 1; e1 = '0; ok = 0; w = '0;
    if (li) begin
`ifdef RVI_ENCODER_LI_EN
      if (v >= -2048 && v <= 2047) begin
        e0 = {2'b01, ((iv & 32'hFFF) << 20) | (rv << 7) | 32'h13};
      end else begin
        hi = ((iv >> 12) + ((iv >> 11) & 32'd1)) & 32'hFFFFF;
        lo = iv & 32'hFFF;
        e0 = {1'b0, lo == 32'd0, (hi << 12) | (rv << 7) | 32'h37};
        if (lo != 32'd0) begin
          n  = 2;
          e1 = {2'b01, (lo << 20) | (rv << 15) | (rv << 7) | 32'h13};
        end
      end
`else
      e0 = {2'b11, 32'd0};
`endif
      return;
    end
    case (op)
      7'h37, 7'h17: begin
        ok = (iv & 32'hFFF) == 0;
        w  = (iv & 32'hFFFFF000) | (rv << 7) | ov;
      end
      7'h6F: begin
        ok = v >= -(1 << 20) && v < (1 << 20) && !iv[0];
        w  = (((iv >> 20) & 1) << 31) | (((iv >> 1) & 32'h3FF) << 21) | (((iv >> 11) & 1) << 20)
           | (((iv >> 12) & 32'hFF) << 12) | (rv << 7) | ov;
      end
      7'h67: begin
        ok = v >= -2048 && v <= 2047;
        w  = ((iv & 32'hFFF) << 20) | (s1 << 15) | (rv << 7) | ov;
      end
      7'h03: begin
        ok = v >= -2048 && v <= 2047 && (fv inside {0, 1, 2, 4, 5});
        w  = ((iv & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (rv << 7) | ov;
      end
      7'h13: begin
        if (fv inside {1, 5, 'h105}) begin
          ok = (iv >> 5) == 0;
          w  = (f7 << 25) | ((iv & 31) << 20) | (s1 << 15) | (f3 << 12) | (rv << 7) | ov;
        end else begin
          ok = v >= -2048 && v <= 2047 && (fv inside {0, 2, 3, 4, 6, 7});
          w  = ((iv & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (rv << 7) | ov;
        end
      end
      7'h23: begin
        ok = v >= -2048 && v <= 2047 && (fv inside {0, 1, 2});
        w  = (((iv >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
           | ((iv & 31) << 7) | ov;
      end
      7'h63: begin
        ok = v >= -4096 && v <= 4095 && !iv[0] && (fv inside {0, 1, 4, 5, 6, 7});
        w  = (((iv >> 12) & 1) << 31) | (((iv >> 5) & 32'h3F) << 25) | (s2 << 20) | (s1 << 15)
           | (f3 << 12) | (((iv >> 1) & 32'hF) << 8) | (((iv >> 11) & 1) << 7) | ov;
      end
      7'h33: begin
        ok = fv inside {0, 1, 2, 3, 4, 5, 6, 7, 'h100, 'h105};
        w  = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (rv << 7) | ov;
      end
      default: ok = 0;
    endcase
    e0 = ok ? {2'b01, w} : {2'b11, 32'd0};
  endfunction

  // Single compare process: every cycle, DUT outputs against the scoreboard.
  bit          armed = 0;
  bit          rst_prev = 0;
  bit          prev_stall = 0;
  logic [33:0] prev_out;
  always @(negedge clk) begin : compare
    logic [33:0] out, e0, e1;
    int          n;
    out = {ins_error, ins_last, ins_data};
    if (rst === 1'b1) begin
      exp_q.delete();
      armed      = 1;
      rst_prev   = 1;
      prev_stall = 0;
      chk(!req_ready, "ready_in_reset", 34'(req_ready), 34'd0);
    end else if (armed) begin
      if (rst_prev) begin
        chk(!ins_valid && out == 34'd0, "reset_outputs", {out[33:1], ins_valid}, 34'd0);
        chk(req_ready, "ready_after_reset", 34'(req_ready), 34'd1);
      end
      chk(ins_valid == (exp_q.size() != 0), "valid_vs_model", 34'(ins_valid),
          34'(exp_q.size() != 0));
      if (prev_stall) chk(ins_valid && out == prev_out, "stall_hold", out, prev_out);
      if (ins_valid && exp_q.size() != 0) begin
        chk(out == exp_q[0], "word", out, exp_q[0]);
        if (ins_ready) void'(exp_q.pop_front());
      end
      if (req_valid && req_ready) begin
        model(req_opcode, req_funct, req_li, req_rd, req_rs1, req_rs2, req_imm, e0, e1, n);
        exp_q.push_back(e0);
        if (n == 2) exp_q.push_back(e1);
      end
      prev_stall = ins_valid && !ins_ready;
      prev_out   = out;
      rst_prev   = 0;
    end
  end

  task automatic send(input logic [6:0] op, input logic [9:0] fn, input logic li,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    int n = 0;
    req_opcode = op; req_funct = fn; req_li = li;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) begin
        chk(0, "accept_timeout", 34'd0, 34'd1);
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_word(input logic [33:0] req, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ins_valid && n < 50);
    chk(ins_valid && {ins_error, ins_last, ins_data} == req, name,
        {ins_error, ins_last, ins_data}, req);
    @(posedge clk); #1;
  endtask

  task automatic rand_req();
    int m;
    req_opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
    req_funct  = ($urandom_range(0, 7) == 0) ? 10'($urandom) : fns[$urandom_range(0, 11)];
    req_li     = ($urandom_range(0, 7) == 0);
    req_rd     = 5'($urandom);
    req_rs1    = 5'($urandom);
    req_rs2    = 5'($urandom);
    m = $urandom_range(0, 6);
    case (m)
      0: req_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1: req_imm = 32'($urandom_range(0, 40));
      2: req_imm = $urandom & 32'hFFFFF000;
      3: req_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      4: req_imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
      5: req_imm = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 1)) << 11;
      default: req_imm = $urandom;
    endcase
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] e0, e1;
    int          n;
    bit          acc;
    rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_funct = '0; req_li = 1'b0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0; ins_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    model(7'h13, 10'h000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, e0, e1, n);
    chk(e0 == 34'h1_00500093 && n == 1, "model_addi", e0, 34'h1_00500093);
    model(7'h63, 10'h000, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd4, e0, e1, n);
    chk(e0 == 34'h1_FE208EE3, "model_beq", e0, 34'h1_FE208EE3);
    model(7'h63, 10'h000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, e0, e1, n);
    chk(e0 == 34'h3_00000000, "model_beq_odd", e0, 34'h3_00000000);
    model(7'h13, 10'h105, 1'b0, 5'd3, 5'd3, 5'd0, 32'd7, e0, e1, n);
    chk(e0 == 34'h1_4071D193, "model_srai", e0, 34'h1_4071D193);
`ifdef RVI_ENCODER_LI_EN
    model(7'h00, 10'h000, 1'b1, 5'd5, 5'd0, 5'd0, 32'h12345FFF, e0, e1, n);
    chk(e0 == 34'h0_123462B7 && n == 2, "model_li_hi", e0, 34'h0_123462B7);
    chk(e1 == 34'h1_FFF28293, "model_li_lo", e1, 34'h1_FFF28293);
`endif

    send(7'h13, 10'h000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    expect_word(34'h1_00500093, "addi_x1_5");
    send(7'h63, 10'h000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    expect_word(34'h1_FE208EE3, "beq_m4");
    send(7'h63, 10'h000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    expect_word(34'h3_00000000, "beq_odd_err");
    send(7'h33, 10'h101, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
    expect_word(34'h3_00000000, "op_bad_funct");
    send(7'h13, 10'h105, 1'b0, 5'd3, 5'd3, 5'd0, 32'd7);
    expect_word(34'h1_4071D193, "srai");
    send(7'h00, 10'h000, 1'b1, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
`ifdef RVI_ENCODER_LI_EN
    expect_word(34'h0_123462B7, "li_lui");
    expect_word(34'h1_FFF28293, "li_addi");
    send(7'h00, 10'h000, 1'b1, 5'd5, 5'd0, 5'd0, 32'h00001000);
    expect_word(34'h1_000012B7, "li_lui_only");
`else
    expect_word(34'h3_00000000, "li_disabled_err");
`endif

    // Back-pressure: two words fill the FIFO, the third waits.
    ins_ready = 1'b0;
    send(7'h13, 10'h000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    send(7'h13, 10'h000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
    req_rd = 5'd3; req_imm = 32'd3; req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk(!req_ready, "full_ready_low", 34'(req_ready), 34'd0);
      chk({ins_error, ins_last, ins_data} == 34'h1_00100093, "stall_head",
          {ins_error, ins_last, ins_data}, 34'h1_00100093);
    end
    @(posedge clk); #1;
    ins_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    chk(req_ready, "third_accepted", 34'(req_ready), 34'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Reset while a second word is pending must drop it and flush the FIFO.
    ins_ready = 1'b0;
    send(7'h13, 10'h000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    send(7'h00, 10'h000, 1'b1, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    @(negedge clk);
    chk(ins_valid && !req_ready, "pending_ready_low", {32'd0, ins_valid, req_ready}, 34'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ins_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk(!ins_valid, "no_word_after_reset", 34'(ins_valid), 34'd0);
    end
    @(posedge clk); #1;

    acc = 0;
    for (int c = 0; c < 3000; c++) begin
      ins_ready = (c >= 2500) ? 1'b1 : ($urandom_range(0, 9) < 7);
      if (!req_valid || acc) begin
        if (c >= 2500 || $urandom_range(0, 3) != 0) begin
          rand_req();
          req_valid = 1'b1;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    ins_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk(exp_q.size() == 0 && !ins_valid, "drain_empty", 34'(exp_q.size()), 34'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rvi_encoder.md
# rvi_encoder

Streaming RV32I instruction encoder: accepts decoded instruction fields (opcode, `{funct7,funct3}`, registers, 32-bit immediate) over a valid/ready handshake and emits packed 32-bit instruction words through a small output FIFO. It is the inverse of the core's instruction decode path. It uses the shared `rvi_pkg` opcode and funct encodings. It sits in front of instruction memory loaders, self-test generators and bench stimulus.

## Interface
- `DEPTH`, 2: output FIFO entries; must be a power of two and at least 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_opcode`  in  7  `rvi_pkg::opcode_t`.
- `req_funct`  in  10  `{funct7,funct3}`, in the same layout as the `rvi_pkg` funct enums.
- `req_li`  in  1  load-immediate pseudo-op request (see Configuration).
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register indices.
- `req_imm`  in  32  byte-offset / value immediate.
- `ins_valid`  out  1  output word valid.
- `ins_ready`  in  1  consumer ready.
- `ins_data`  out  32  encoded instruction word.
- `ins_last`  out  1  last word of the current request.
- `ins_error`  out  1  request was unencodable; `ins_data` is 0.

## Operation
- Supported formats:
  - LUI and AUIPC use U-type.
  - JAL uses J-type.
  - JALR uses I-type with funct3=000.
  - LOAD uses I-type and the `load_funct_t` values.
  - OP_IMM uses I-type and the `op_imm_funct_t` values. For SLLI/SRLI/SRAI, imm[11:5] = funct7 and shamt = `req_imm[4:0]`.
  - STORE uses S-type and the `store_funct_t` values.
  - BRANCH uses B-type and the `branch_funct_t` values.
  - OP uses R-type and the `op_funct_t` values.
- Error conditions. Any of the following produces one word with `ins_data`=0, `ins_error`=1, `ins_last`=1:
  - Any other opcode.
  - `req_funct` not in the enum for the given opcode.
  - Immediate not representable:
    - I/S: `req_imm` is not a 12-bit signed value.
    - B: not 13-bit signed, or bit0 ≠ 0.
    - J: not 21-bit signed, or bit0 ≠ 0.
    - U: `req_imm[11:0]` ≠ 0.
    - Shift: `req_imm[31:5]` ≠ 0.
- Field checks that do not apply to a format are ignored (for example rs2 for I-type).
- State machine: IDLE and LI_LO.
  - IDLE: `req_ready` = !rst && !fifo_full. On accept, push one word, or the first word of an LI expansion.
  - IDLE→LI_LO: taken when the LI expansion needs a second word.
  - LI_LO: `req_ready`=0. Push ADDI rd,rd,lo as soon as the FIFO is not full, then return to IDLE.
- FIFO: push only when not full. When the FIFO is full, no pop-through push is allowed in the same cycle. Pops occur on `ins_valid && ins_ready`. Data stays in order.

## Timing
- Reset values:
  - State is IDLE and the FIFO is empty.
  - `ins_valid`=0, `ins_data`=0, `ins_last`=0, `ins_error`=0.
  - `req_ready`=0 while `rst` is high, and 1 in the first cycle after release.
- Latency: a request accepted in cycle N is presented at the FIFO head in cycle N+1 if the FIFO was empty. The second LI word is presented no earlier than N+2.
- While `ins_valid`=1 and `ins_ready`=0, `ins_data`, `ins_last` and `ins_error` hold stable.
- Maximum throughput is one word per cycle with `ins_ready` held high.
- Reset during LI_LO drops the pending ADDI and flushes the FIFO.
- A FIFO pointer wrap at `DEPTH` entries needs no bubble.

## Configuration
- `RVI_ENCODER_LI_EN`
  - Defined: a request with `req_li`=1 ignores `req_opcode` and `req_funct`.
    - If `req_imm` fits 12-bit signed: emit ADDI rd,x0,imm.
    - Otherwise: hi = `req_imm[31:12]` + `req_imm[11]`, computed mod 2^20, and lo = `req_imm[11:0]`. Emit LUI rd,hi with `ins_last`=0, then ADDI rd,rd,lo with `ins_last`=1.
    - If lo = 0, emit the LUI alone with `ins_last`=1.
  - Undefined: LI_LO is not built and `req_li`=1 yields an error word.

## Test plan
- ADDI x1,x0,5 with `ins_ready`=1 → one cycle later `ins_data`=32'h00500093, `ins_last`=1, `ins_error`=0.
- BEQ x1,x2,imm=-4 → 32'hFE208EE3. BRANCH with imm=3 → `ins_data`=0, `ins_error`=1.
- OP with `req_funct`=10'b0100000001 → error word. SRAI x3,x3,7 → 32'h4071D193.
- LI x5,32'h12345FFF, `RVI_ENCODER_LI_EN` defined → 32'h123462B7 with last=0, then 32'hFFF28293 with last=1. LI x5,32'h00001000 → 32'h000012B7 alone with last=1.
- `DEPTH`=2, `ins_ready`=0, three ADDI requests → two are accepted, `req_ready` drops, and the head holds stable. Releasing `ins_ready` drains all three in order.
- Start an LI, assert `rst` after the LUI is pushed → next cycle `ins_valid`=0 and no ADDI is ever emitted.
